// File: rtl/inv_key_schedule_pkg.sv
// Shared AES-128 key-schedule constants, state encoding and Rcon lookup.
// Purely declarative; no latency or backpressure of its own.
package inv_key_schedule_pkg;

    localparam int AES_NR    = 10;
    localparam int AES_KEY_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EMIT   = 2'd1,
        ST_EXPAND = 2'd2
    } ks_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/inv_key_schedule_if.sv
// Control and round-key stream bundle between key storage and the inverse round engine.
// Key_is_cipher exists only when INV_KS_CIPHER_LOAD_EN is defined.
// Backpressure: out_valid/out_ready handshake on the round-key stream.
interface inv_key_schedule_if
    import inv_key_schedule_pkg::*;
;
    logic                 start;
    logic [AES_KEY_W-1:0] key_in;
`ifdef INV_KS_CIPHER_LOAD_EN
    logic                 key_is_cipher;
`endif
    logic                 out_valid;
    logic                 out_ready;
    logic [AES_KEY_W-1:0] out_key;
    logic [3:0]           out_round;
    logic                 busy;
    logic                 done;

    modport slave (
`ifdef INV_KS_CIPHER_LOAD_EN
        input  key_is_cipher,
`endif
        input  start, key_in, out_ready,
        output out_valid, out_key, out_round, busy, done
    );

    modport master (
`ifdef INV_KS_CIPHER_LOAD_EN
        output key_is_cipher,
`endif
        output start, key_in, out_ready,
        input  out_valid, out_key, out_round, busy, done
    );
endinterface

// File: rtl/inv_key_schedule_round_key.sv
// One inverse AES-128 key-expansion step: round key r to round key r-1.
// Latency: combinational. Backpressure: none.
module inv_round_key
    import inv_key_schedule_pkg::*;
(
    input  logic [AES_KEY_W-1:0] rk,
    input  logic [3:0]           rc_idx,
    output logic [AES_KEY_W-1:0] prev_rk
);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w1_n, w2_n, w3_n;
    logic [31:0] rot_w, sub_w;

    assign w0 = rk[127:96];
    assign w1 = rk[95:64];
    assign w2 = rk[63:32];
    assign w3 = rk[31:0];

    assign w3_n  = w3 ^ w2;
    assign w2_n  = w2 ^ w1;
    assign w1_n  = w1 ^ w0;
    assign rot_w = {w3_n[23:0], w3_n[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        subByte u_sbox (
            .in_i  (rot_w[8*b +: 8]),
            .inv_i (1'b0),
            .out_o (sub_w[8*b +: 8])
        );
    end

    assign prev_rk = {w0 ^ sub_w ^ {rcon(rc_idx), 24'h0}, w1_n, w2_n, w3_n};
endmodule

// File: rtl/subByte.sv
// AES S-box (forward, or inverse when inv_i=1) built from GF(2^8) inversion and the affine map.
// Latency: combinational. Backpressure: none.
module subByte (
    input  logic [7:0] in_i,
    input  logic       inv_i,
    output logic [7:0] out_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 by a square-and-multiply chain; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int k = 1; k < 8; k++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl(a, 1) ^ rotl(a, 2) ^ rotl(a, 3) ^ rotl(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
    endfunction

    always_comb begin
        out_o = inv_i ? gf_inv(inv_affine(in_i)) : affine(gf_inv(in_i));
    end
endmodule

// File: rtl/inv_key_schedule.sv
// Streams AES-128 round keys 10..0 from a round-10 key, one per accepted beat.
// Latency: first key the cycle after start; with INV_KS_CIPHER_LOAD_EN a cipher key costs 10 extra cycles.
// Backpressure: out_ready low holds key/round stable indefinitely.
module inv_key_schedule
    import inv_key_schedule_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    inv_key_schedule_if.slave        ks
);
    ks_state_e            state_q, state_d;
    logic [3:0]           round_q, round_d;
    logic [AES_KEY_W-1:0] key_q,   key_d;
    logic                 done_q,  done_d;
    logic [AES_KEY_W-1:0] prev_key;

    inv_round_key u_step (
        .rk      (key_q),
        .rc_idx  (round_q - 4'd1),
        .prev_rk (prev_key)
    );

`ifdef INV_KS_CIPHER_LOAD_EN
    // Forward expansion; round_q doubles as the Rcon index while expanding.
    logic [31:0]          fw_rot, fw_sub, f0, f1, f2, f3;
    logic [AES_KEY_W-1:0] fwd_key;

    assign fw_rot = {key_q[23:0], key_q[31:24]};
    for (genvar b = 0; b < 4; b++) begin : g_fwd_sbox
        subByte u_sbox (
            .in_i  (fw_rot[8*b +: 8]),
            .inv_i (1'b0),
            .out_o (fw_sub[8*b +: 8])
        );
    end
    assign f0      = key_q[127:96] ^ fw_sub ^ {rcon(round_q), 24'h0};
    assign f1      = key_q[95:64] ^ f0;
    assign f2      = key_q[63:32] ^ f1;
    assign f3      = key_q[31:0]  ^ f2;
    assign fwd_key = {f0, f1, f2, f3};
`endif

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        key_d   = key_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ks.start) begin
                    key_d   = ks.key_in;
                    round_d = 4'(AES_NR);
                    state_d = ST_EMIT;
`ifdef INV_KS_CIPHER_LOAD_EN
                    if (ks.key_is_cipher) begin
                        round_d = 4'd0;
                        state_d = ST_EXPAND;
                    end
`endif
                end
            end
            ST_EMIT: begin
                if (ks.out_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = prev_key;
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
`ifdef INV_KS_CIPHER_LOAD_EN
            ST_EXPAND: begin
                key_d = fwd_key;
                if (round_q == 4'(AES_NR - 1)) begin
                    round_d = 4'(AES_NR);
                    state_d = ST_EMIT;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            round_q <= 4'd0;
            key_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            key_q   <= key_d;
            done_q  <= done_d;
        end
    end

    assign ks.out_valid = (state_q == ST_EMIT);
    assign ks.out_key   = key_q;
    assign ks.out_round = round_q;
    assign ks.busy      = (state_q != ST_IDLE);
    assign ks.done      = done_q;
endmodule
